systolic_setup_controller: RTL and testbench
============================================

# systolic_setup_controller

Sequencer that loads one MAC_WIDTH×MAC_WIDTH operand matrix into the per-row `syn_fifo` bank of the systolic setup stage, then drains the FIFOs with a diagonal skew (row r starts r cycles after row 0) to feed the MAC array. It owns all FIFO `wr_en`/`rd_en` strobes, provides the `matrix_in_request`/`instr` handshake to the upstream loader, and presents skewed data plus per-row valids to the array.

## Interface
- `DATA_SIZE`, 8, element width in bits
- `MAC_WIDTH`, 2, array dimension W (rows = columns = FIFO count); FIFO depth ≥ W
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low; one clock, reset asserted when low
- `instr`  in  1  start strobe; sampled only in IDLE
- `matrix_in`  in  DATA_SIZE·W·W  element (r,c) at bits [(r·W+c)·DATA_SIZE +: DATA_SIZE]
- `matrix_in_request`  out  1  high in IDLE: ready to accept a matrix
- `fifo_in`  out  DATA_SIZE·W  row r FIFO write data at [r·DATA_SIZE +: DATA_SIZE]
- `wr_en`  out  W  per-row FIFO write enable
- `rd_en`  out  W  per-row FIFO read enable
- `full`  in  W  per-row FIFO full
- `empty`  in  W  per-row FIFO empty
- `fifo_out`  in  DATA_SIZE·W  per-row FIFO read data (valid 1 cycle after `rd_en`)
- `data_to_array`  out  DATA_SIZE·W  skewed row data to MAC array; 0 when not valid
- `valid_to_array`  out  W  per-row data valid
- `busy`  out  1  high in LOAD, DRAIN, DONE
- `done`  out  1  one-cycle pulse at end of matrix

## Operation
- States: IDLE → LOAD → DRAIN → DONE → IDLE.
- IDLE: `matrix_in_request`=1. `instr`=1 at an edge captures `matrix_in` into an internal register, clears column counter c, enters LOAD. `instr` in any other state ignored.
- LOAD: per cycle, for every row r: `wr_en[r]`=1, `fifo_in[r]`=element(r,c); c increments. If any `full[r]`=1, all `wr_en` forced 0 and c holds (stall, no row advances alone). After c=W−1 is written, enter DRAIN with skew counter t=0.
- DRAIN: `rd_en[r]`=1 iff r ≤ t ≤ r+W−1. t increments each cycle, runs 0..2W−1 (last cycle only flushes final valid). If any row scheduled to read has `empty[r]`=1, all `rd_en` forced 0 and t holds (skew preserved). After t=2W−1 enter DONE.
- `valid_to_array[r]` = `rd_en[r]` delayed one cycle; `data_to_array[r]` = `fifo_out[r]` when valid, else 0.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- Counters c, t are ⌈log2(2W)⌉ bits; no wrap within a matrix.
- FIFO contents are not flushed by this block; FIFOs share the system reset.

## Timing
- Reset (async, while `reset`=0): state IDLE, `matrix_in_request`=1, all other outputs 0, counters 0, capture register 0. Reset mid-LOAD/DRAIN aborts immediately; no `done`.
- Unstalled: `instr` sampled at edge E0 → `wr_en` high cycles 1..W after E0; `rd_en[r]` high DRAIN cycles r..r+W−1; `valid_to_array[r]` high DRAIN cycles r+1..r+W; `done` in cycle W+2W+1 after E0.
- Total unstalled latency `instr` to `done`: 3W+1 cycles (W=2: 7). `matrix_in_request` low from cycle 1 through DONE.
- Simultaneous `full` and last LOAD write: write suppressed, retried next cycle.
- `instr` held high through DONE→IDLE: new matrix accepted at the first edge in IDLE.

## Test plan
- W=2, `matrix_in` elements 0x11,0x12,0x21,0x22, `instr` pulse -> row0 writes 0x11,0x12; row1 writes 0x21,0x22 in LOAD cycles 1,2.
- Same run, drain -> `data_to_array` row0 0x11,0x12 at DRAIN cycles 1,2; row1 0x21,0x22 at cycles 2,3; `done` at cycle 7 after `instr`.
- `full[1]`=1 for 2 cycles during LOAD c=1 -> `wr_en` both 0 those cycles, 0x12/0x22 written after release, `done` delayed 2 cycles.
- `empty[0]`=1 one cycle at DRAIN t=1 -> all `rd_en` 0, skew preserved (row1 still one cycle behind row0).
- `reset` low mid-DRAIN -> all outputs 0, `matrix_in_request`=1 immediately; no `done`.
- `instr` pulsed in LOAD and DRAIN -> ignored; back-to-back `instr` held high -> second matrix starts the cycle after IDLE is re-entered.

Source files
------------

// File: rtl/systolic_setup_controller.sv
// Systolic setup sequencer: captures one MAC_WIDTH x MAC_WIDTH matrix, loads it
// column-by-column into the per-row FIFOs, then drains them with a diagonal skew.
module systolic_setup_controller #(
    parameter int DATA_SIZE = 8,
    parameter int MAC_WIDTH = 2
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic                                     instr,
    input  logic [DATA_SIZE*MAC_WIDTH*MAC_WIDTH-1:0] matrix_in,
    output logic                                     matrix_in_request,
    output logic [DATA_SIZE*MAC_WIDTH-1:0]           fifo_in,
    output logic [MAC_WIDTH-1:0]                     wr_en,
    output logic [MAC_WIDTH-1:0]                     rd_en,
    input  logic [MAC_WIDTH-1:0]                     full,
    input  logic [MAC_WIDTH-1:0]                     empty,
    input  logic [DATA_SIZE*MAC_WIDTH-1:0]           fifo_out,
    output logic [DATA_SIZE*MAC_WIDTH-1:0]           data_to_array,
    output logic [MAC_WIDTH-1:0]                     valid_to_array,
    output logic                                     busy,
    output logic                                     done
);

    localparam int CW = (MAC_WIDTH > 1) ? $clog2(2 * MAC_WIDTH) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(MAC_WIDTH - 1);
    localparam logic [CW-1:0] T_LAST = CW'(2 * MAC_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e                                   state_q;
    logic [CW-1:0]                            c_q;
    logic [CW-1:0]                            t_q;
    logic [DATA_SIZE*MAC_WIDTH*MAC_WIDTH-1:0] mat_q;
    logic [MAC_WIDTH-1:0]                     valid_q;

    logic                                     load_stall;
    logic                                     drain_stall;
    logic [MAC_WIDTH-1:0]                     rd_sched;

    assign load_stall = |full;

    // A row is scheduled while t lies in its skewed window [r, r+W-1]; any
    // scheduled row being empty freezes every row so the skew is kept intact.
    always_comb begin
        rd_sched = '0;
        for (int unsigned r = 0; r < MAC_WIDTH; r++) begin
            rd_sched[r] = (state_q == S_DRAIN) &&
                          (32'(t_q) >= r) && (32'(t_q) <= r + MAC_WIDTH - 1);
        end
        drain_stall = |(rd_sched & empty);
        rd_en       = drain_stall ? '0 : rd_sched;
    end

    always_comb begin
        fifo_in = '0;
        if (state_q == S_LOAD) begin
            for (int unsigned r = 0; r < MAC_WIDTH; r++) begin
                for (int unsigned cc = 0; cc < MAC_WIDTH; cc++) begin
                    if (c_q == CW'(cc)) begin
                        fifo_in[r*DATA_SIZE +: DATA_SIZE] =
                            mat_q[(r*MAC_WIDTH + cc)*DATA_SIZE +: DATA_SIZE];
                    end
                end
            end
        end
    end

    always_comb begin
        data_to_array = '0;
        for (int unsigned r = 0; r < MAC_WIDTH; r++) begin
            if (valid_q[r]) begin
                data_to_array[r*DATA_SIZE +: DATA_SIZE] = fifo_out[r*DATA_SIZE +: DATA_SIZE];
            end
        end
    end

    assign wr_en             = (state_q == S_LOAD && !load_stall) ? '1 : '0;
    assign valid_to_array    = valid_q;
    assign matrix_in_request = (state_q == S_IDLE);
    assign busy              = (state_q != S_IDLE);
    assign done              = (state_q == S_DONE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            c_q     <= '0;
            t_q     <= '0;
            mat_q   <= '0;
            valid_q <= '0;
        end else begin
            valid_q <= rd_en;
            case (state_q)
                S_IDLE: begin
                    if (instr) begin
                        mat_q   <= matrix_in;
                        c_q     <= '0;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (!load_stall) begin
                        if (c_q == C_LAST) begin
                            t_q     <= '0;
                            state_q <= S_DRAIN;
                        end else begin
                            c_q <= c_q + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!drain_stall) begin
                        if (t_q == T_LAST) begin
                            state_q <= S_DONE;
                        end else begin
                            t_q <= t_q + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_setup_controller.sv
// Directed bench for systolic_setup_controller (W=2) with a small behavioural
// FIFO bank; every cycle's outputs are compared against hand-derived values.
module tb_systolic_setup_controller;

    logic        clock;
    logic        reset;
    logic        instr;
    logic [31:0] matrix_in;
    logic        matrix_in_request;
    logic [15:0] fifo_in;
    logic [1:0]  wr_en;
    logic [1:0]  rd_en;
    logic [1:0]  full;
    logic [1:0]  empty;
    logic [15:0] fifo_out;
    logic [15:0] data_to_array;
    logic [1:0]  valid_to_array;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    systolic_setup_controller #(.DATA_SIZE(8), .MAC_WIDTH(2)) dut (
        .clock             (clock),
        .reset             (reset),
        .instr             (instr),
        .matrix_in         (matrix_in),
        .matrix_in_request (matrix_in_request),
        .fifo_in           (fifo_in),
        .wr_en             (wr_en),
        .rd_en             (rd_en),
        .full              (full),
        .empty             (empty),
        .fifo_out          (fifo_out),
        .data_to_array     (data_to_array),
        .valid_to_array    (valid_to_array),
        .busy              (busy),
        .done              (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Row FIFOs: registered read data, cleared by the shared reset.
    logic [7:0] mem [2][16];
    logic [3:0] wp [2];
    logic [3:0] rp [2];

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < 2; r++) begin
                wp[r] <= '0;
                rp[r] <= '0;
            end
            fifo_out <= '0;
        end else begin
            for (int r = 0; r < 2; r++) begin
                if (wr_en[r]) begin
                    mem[r][wp[r]] <= fifo_in[r*8 +: 8];
                    wp[r]         <= wp[r] + 4'd1;
                end
                if (rd_en[r]) begin
                    fifo_out[r*8 +: 8] <= mem[r][rp[r]];
                    rp[r]              <= rp[r] + 4'd1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs for the current cycle are already driven; compare at the falling
    // edge, then advance to just after the next rising edge.
    task automatic expect_cycle(input string tst, input int k,
                                input logic [1:0] wr, input logic [1:0] rd,
                                input logic [1:0] vld, input logic [15:0] fin,
                                input logic [15:0] dat, input logic dn,
                                input logic req);
        @(negedge clock);
        chk($sformatf("%s c%0d wr_en", tst, k), 32'(wr_en), 32'(wr));
        chk($sformatf("%s c%0d rd_en", tst, k), 32'(rd_en), 32'(rd));
        chk($sformatf("%s c%0d valid", tst, k), 32'(valid_to_array), 32'(vld));
        chk($sformatf("%s c%0d fifo_in", tst, k), 32'(fifo_in), 32'(fin));
        chk($sformatf("%s c%0d data", tst, k), 32'(data_to_array), 32'(dat));
        chk($sformatf("%s c%0d done", tst, k), 32'(done), 32'(dn));
        chk($sformatf("%s c%0d request", tst, k), 32'(matrix_in_request), 32'(req));
        chk($sformatf("%s c%0d busy", tst, k), 32'(busy), 32'(!req));
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        instr     = 1'b0;
        matrix_in = '0;
        full      = '0;
        empty     = '0;

        expect_cycle("reset", 0, 2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b1);
        reset = 1'b1;
        expect_cycle("idle", 0, 2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b1);

        // Unstalled matrix: row0 = 11,12 ; row1 = 21,22
        instr = 1'b1; matrix_in = 32'h2221_1211;
        expect_cycle("basic", 0, 2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b1);
        instr = 1'b0;
        expect_cycle("basic", 1, 2'b11, 2'b00, 2'b00, 16'h2111, 16'h0000, 1'b0, 1'b0);
        expect_cycle("basic", 2, 2'b11, 2'b00, 2'b00, 16'h2212, 16'h0000, 1'b0, 1'b0);
        expect_cycle("basic", 3, 2'b00, 2'b01, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0);
        expect_cycle("basic", 4, 2'b00, 2'b11, 2'b01, 16'h0000, 16'h0011, 1'b0, 1'b0);
        expect_cycle("basic", 5, 2'b00, 2'b10, 2'b11, 16'h0000, 16'h2112, 1'b0, 1'b0);
        expect_cycle("basic", 6, 2'b00, 2'b00, 2'b10, 16'h0000, 16'h2200, 1'b0, 1'b0);
        expect_cycle("basic", 7, 2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0);
        expect_cycle("basic", 8, 2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b1);

        // full[1] during the c=1 write for two cycles: row0 = 31,32 ; row1 = 41,42
        instr = 1'b1; matrix_in = 32'h4241_3231;
        expect_cycle("full", 0, 2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b1);
        instr = 1'b0;
        expect_cycle("full", 1, 2'b11, 2'b00, 2'b00, 16'h4131, 16'h0000, 1'b0, 1'b0);
        full = 2'b10;
        expect_cycle("full", 2, 2'b00, 2'b00, 2'b00, 16'h4232, 16'h0000, 1'b0, 1'b0);
        expect_cycle("full", 3, 2'b00, 2'b00, 2'b00, 16'h4232, 16'h0000, 1'b0, 1'b0);
        full = 2'b00;
        expect_cycle("full", 4, 2'b11, 2'b00, 2'b00, 16'h4232, 16'h0000, 1'b0, 1'b0);
        expect_cycle("full", 5, 2'b00, 2'b01, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0);
        expect_cycle("full", 6, 2'b00, 2'b11, 2'b01, 16'h0000, 16'h0031, 1'b0, 1'b0);
        expect_cycle("full", 7, 2'b00, 2'b10, 2'b11, 16'h0000, 16'h4132, 1'b0, 1'b0);
        expect_cycle("full", 8, 2'b00, 2'b00, 2'b10, 16'h0000, 16'h4200, 1'b0, 1'b0);
        expect_cycle("full", 9, 2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0);
        expect_cycle("full", 10, 2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b1);

        // empty[0] at t=1 stalls both rows: row0 = 51,52 ; row1 = 61,62
        instr = 1'b1; matrix_in = 32'h6261_5251;
        expect_cycle("empty", 0, 2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b1);
        instr = 1'b0;
        expect_cycle("empty", 1, 2'b11, 2'b00, 2'b00, 16'h6151, 16'h0000, 1'b0, 1'b0);
        expect_cycle("empty", 2, 2'b11, 2'b00, 2'b00, 16'h6252, 16'h0000, 1'b0, 1'b0);
        expect_cycle("empty", 3, 2'b00, 2'b01, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0);
        empty = 2'b01;
        expect_cycle("empty", 4, 2'b00, 2'b00, 2'b01, 16'h0000, 16'h0051, 1'b0, 1'b0);
        empty = 2'b00;
        expect_cycle("empty", 5, 2'b00, 2'b11, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0);
        expect_cycle("empty", 6, 2'b00, 2'b10, 2'b11, 16'h0000, 16'h6152, 1'b0, 1'b0);
        expect_cycle("empty", 7, 2'b00, 2'b00, 2'b10, 16'h0000, 16'h6200, 1'b0, 1'b0);
        expect_cycle("empty", 8, 2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0);
        expect_cycle("empty", 9, 2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b1);

        // instr held high throughout: ignored while busy, second matrix
        // accepted on the first IDLE edge; matrix_in changes mid-run are ignored.
        instr = 1'b1; matrix_in = 32'h8281_7271;
        expect_cycle("b2b", 0, 2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b1);
        matrix_in = 32'hB2B1_A2A1;
        expect_cycle("b2b", 1, 2'b11, 2'b00, 2'b00, 16'h8171, 16'h0000, 1'b0, 1'b0);
        expect_cycle("b2b", 2, 2'b11, 2'b00, 2'b00, 16'h8272, 16'h0000, 1'b0, 1'b0);
        expect_cycle("b2b", 3, 2'b00, 2'b01, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0);
        expect_cycle("b2b", 4, 2'b00, 2'b11, 2'b01, 16'h0000, 16'h0071, 1'b0, 1'b0);
        expect_cycle("b2b", 5, 2'b00, 2'b10, 2'b11, 16'h0000, 16'h8172, 1'b0, 1'b0);
        expect_cycle("b2b", 6, 2'b00, 2'b00, 2'b10, 16'h0000, 16'h8200, 1'b0, 1'b0);
        expect_cycle("b2b", 7, 2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0);
        expect_cycle("b2b", 8, 2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b1);
        instr = 1'b0;
        expect_cycle("b2b", 9, 2'b11, 2'b00, 2'b00, 16'hB1A1, 16'h0000, 1'b0, 1'b0);
        expect_cycle("b2b", 10, 2'b11, 2'b00, 2'b00, 16'hB2A2, 16'h0000, 1'b0, 1'b0);
        expect_cycle("b2b", 11, 2'b00, 2'b01, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0);
        expect_cycle("b2b", 12, 2'b00, 2'b11, 2'b01, 16'h0000, 16'h00A1, 1'b0, 1'b0);
        expect_cycle("b2b", 13, 2'b00, 2'b10, 2'b11, 16'h0000, 16'hB1A2, 1'b0, 1'b0);
        expect_cycle("b2b", 14, 2'b00, 2'b00, 2'b10, 16'h0000, 16'hB200, 1'b0, 1'b0);
        expect_cycle("b2b", 15, 2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0);
        expect_cycle("b2b", 16, 2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b1);

        // Reset asserted mid-DRAIN aborts at once, with no done afterwards.
        instr = 1'b1; matrix_in = 32'hD2D1_C2C1;
        expect_cycle("abort", 0, 2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b1);
        instr = 1'b0;
        expect_cycle("abort", 1, 2'b11, 2'b00, 2'b00, 16'hD1C1, 16'h0000, 1'b0, 1'b0);
        expect_cycle("abort", 2, 2'b11, 2'b00, 2'b00, 16'hD2C2, 16'h0000, 1'b0, 1'b0);
        expect_cycle("abort", 3, 2'b00, 2'b01, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0);
        expect_cycle("abort", 4, 2'b00, 2'b11, 2'b01, 16'h0000, 16'h00C1, 1'b0, 1'b0);
        reset = 1'b0;
        expect_cycle("abort", 5, 2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b1);
        reset = 1'b1;
        for (int k = 6; k < 11; k++) begin
            expect_cycle("abort", k, 2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
